// File: rtl/disp_scan.sv
// 6-digit multiplexed 7-segment display driver for the washer controller:
// snapshots tot/cur/wat per frame, shows them in BCD with leading-zero blanking and pause blink.

module disp_bcd (
  input  logic [5:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [5:0] r;
  always_comb begin
    tens = 4'd0;
    r    = v;
    // Weights 40/20/10 cover the whole 0..63 range in three compare/subtract steps
    if (r >= 6'd40) begin tens = tens + 4'd4; r = r - 6'd40; end
    if (r >= 6'd20) begin tens = tens + 4'd2; r = r - 6'd20; end
    if (r >= 6'd10) begin tens = tens + 4'd1; r = r - 6'd10; end
    ones = r[3:0];
  end
endmodule

module disp_scan #(
  parameter int SCAN_CMAX  = 50000,     // 1 ms at 50 MHz
  parameter int BLINK_CMAX = 25000000   // 500 ms at 50 MHz
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [5:0] u_tot,
  input  logic [5:0] u_cur,
  input  logic [5:0] u_wat,
  input  logic       fl_disp,
  output logic [5:0] an_n,
  output logic [7:0] seg_n
);
  localparam int SW = $clog2(SCAN_CMAX);
  localparam int BW = $clog2(BLINK_CMAX);
  localparam int NPAIR = 3;

  logic [SW-1:0]           cnt;
  logic [BW-1:0]           bcnt;
  logic [2:0]              digit;
  logic                    phase_on;
  logic [NPAIR-1:0][5:0]   snap;   // [2]=tot, [1]=cur, [0]=wat
  logic [NPAIR-1:0][3:0]   tens, ones;

  logic       scan_term, blink_term, is_tens, blank;
  logic [1:0] pair;
  logic [3:0] dval;
  logic [5:0] an_nxt;
  logic [7:0] seg_nxt;

  for (genvar i = 0; i < NPAIR; i++) begin : g_bcd
    disp_bcd u_bcd (.v(snap[i]), .tens(tens[i]), .ones(ones[i]));
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign scan_term  = (cnt == SW'(SCAN_CMAX - 1));
  assign blink_term = (bcnt == BW'(BLINK_CMAX - 1));

  always_comb begin
    pair    = digit[2:1];
    is_tens = digit[0];
    dval    = is_tens ? tens[pair] : ones[pair];
    blank   = (is_tens && tens[pair] == 4'd0) || (!phase_on && digit >= 3'd2);
    seg_nxt = blank ? 8'hFF : seg7(dval);
    an_nxt  = blank ? 6'h3F : ~(6'd1 << digit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      bcnt     <= '0;
      digit    <= 3'd0;
      phase_on <= 1'b1;
      snap     <= '0;
      an_n     <= 6'h3F;
      seg_n    <= 8'hFF;
    end else if (!en) begin
      cnt      <= '0;
      bcnt     <= '0;
      digit    <= 3'd0;
      phase_on <= 1'b1;
      snap     <= {u_tot, u_cur, u_wat};
      an_n     <= 6'h3F;
      seg_n    <= 8'hFF;
    end else begin
      an_n  <= an_nxt;
      seg_n <= seg_nxt;
      if (scan_term) begin
        cnt <= '0;
        if (digit == 3'd5) begin
          digit <= 3'd0;
          snap  <= {u_tot, u_cur, u_wat};  // frame wrap: new values start at digit 0
        end else begin
          digit <= digit + 3'd1;
        end
      end else begin
        cnt <= cnt + SW'(1);
      end
      if (!fl_disp) begin
        bcnt     <= '0;
        phase_on <= 1'b1;
      end else if (blink_term) begin
        bcnt     <= '0;
        phase_on <= ~phase_on;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_disp_scan.sv
// Bench for disp_scan: per-cycle comparison against a timeline model (cycles since
// enable, cycles since blink start, frame-wrap snapshots) plus directed scenario checks.

module tb_disp_scan;
  localparam int SC = 4;
  localparam int BC = 16;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, fl_disp = 1'b0;
  logic [5:0] u_tot = 6'd0, u_cur = 6'd0, u_wat = 6'd0;
  logic [5:0] an_n;
  logic [7:0] seg_n;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  disp_scan #(.SCAN_CMAX(SC), .BLINK_CMAX(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .u_tot(u_tot), .u_cur(u_cur),
    .u_wat(u_wat), .fl_disp(fl_disp), .an_n(an_n), .seg_n(seg_n)
  );

  // Reference model: position in the frame is cycles-since-enable / dwell
  logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int run = 0, fl_run = 0;
  int snap [3] = '{0, 0, 0};
  logic [5:0] exp_an = 6'h3F;
  logic [7:0] exp_seg = 8'hFF;

  always @(posedge clk) begin
    int d, v, t, o;
    bit off;
    if (!rst_n) begin
      exp_an = 6'h3F; exp_seg = 8'hFF; run = 0; fl_run = 0;
      snap[0] = 0; snap[1] = 0; snap[2] = 0;
    end else if (!en) begin
      exp_an = 6'h3F; exp_seg = 8'hFF; run = 0; fl_run = 0;
      snap[0] = u_wat; snap[1] = u_cur; snap[2] = u_tot;
    end else begin
      d = (run / SC) % 6;
      v = snap[d / 2];
      t = v / 10;
      o = v % 10;
      off = ((fl_run / BC) % 2) == 1;
      if ((d % 2 == 1 && t == 0) || (off && d >= 2)) begin
        exp_an = 6'h3F; exp_seg = 8'hFF;
      end else begin
        exp_an = ~(6'd1 << d);
        exp_seg = seg_lut[(d % 2 == 1) ? t : o];
      end
      if (run % (6 * SC) == 6 * SC - 1) begin
        snap[0] = u_wat; snap[1] = u_cur; snap[2] = u_tot;
      end
      run++;
      fl_run = fl_disp ? fl_run + 1 : 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    tick(); tick();
    checks++;
    if (an_n !== 6'h3F || seg_n !== 8'hFF) begin
      errors++;
      $display("FAIL reset: an_n=%h seg_n=%h, want 3f ff", an_n, seg_n);
    end
  endtask

  task automatic test_zero();
    en = 1'b1; rst_n = 1'b1;
    tick();
    checks++;
    if (an_n !== 6'h3E || seg_n !== 8'hC0) begin
      errors++;
      $display("FAIL zero_d0: an_n=%h seg_n=%h, want 3e c0", an_n, seg_n);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL zero_model: an_n=%h seg_n=%h, want %h %h", an_n, seg_n, exp_an, exp_seg);
      end
    end
    checks++;
    if (an_n !== 6'h3F) begin
      errors++;
      $display("FAIL zero_d1_blank: an_n=%h, want 3f", an_n);
    end
  endtask

  task automatic test_static();
    logic [7:0] seen [6];
    int lit [6];
    u_tot = 6'd45; u_cur = 6'd7; u_wat = 6'd63;
    for (int k = 0; k < 6; k++) begin seen[k] = 8'hFF; lit[k] = 0; end
    for (int i = 0; i < 72; i++) begin
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL static_model: an_n=%h seg_n=%h, want %h %h", an_n, seg_n, exp_an, exp_seg);
      end
      checks++;
      if (an_n !== 6'h3F && $countones(~an_n) != 1) begin
        errors++;
        $display("FAIL static_onehot: an_n=%h, want at most one low bit", an_n);
      end
      if (i >= 48)
        for (int k = 0; k < 6; k++)
          if (an_n[k] == 1'b0) begin seen[k] = seg_n; lit[k]++; end
    end
    checks++;
    if (seen[5] !== 8'h99 || seen[4] !== 8'h92 || seen[2] !== 8'hF8 ||
        seen[1] !== 8'h82 || seen[0] !== 8'hB0 || lit[3] != 0) begin
      errors++;
      $display("FAIL static_digits: d5..d0=%h %h %h %h %h %h lit3=%0d, want 99 92 ff f8 82 b0 0",
               seen[5], seen[4], seen[3], seen[2], seen[1], seen[0], lit[3]);
    end
    checks++;
    if (lit[0] != SC || lit[1] != SC || lit[2] != SC || lit[4] != SC || lit[5] != SC) begin
      errors++;
      $display("FAIL static_dwell: lit=%0d %0d %0d %0d %0d, want %0d each",
               lit[0], lit[1], lit[2], lit[4], lit[5], SC);
    end
  endtask

  task automatic test_no_tear();
    int n = 0;
    while (an_n !== 6'h3B && n < 40) begin tick(); n++; end
    checks++;
    if (an_n !== 6'h3B) begin
      errors++;
      $display("FAIL tear_wait: an_n=%h, digit 2 never lit", an_n);
    end
    u_tot = 6'd12;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL tear_model: an_n=%h seg_n=%h, want %h %h", an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_blink();
    fl_disp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL blink_model: an_n=%h seg_n=%h, want %h %h", an_n, seg_n, exp_an, exp_seg);
      end
    end
    for (int i = 0; i < 40 && ((fl_run / BC) % 2) == 0; i++) tick();
    fl_disp = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL unblink_model: an_n=%h seg_n=%h, want %h %h", an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_enable();
    repeat (9) tick();
    en = 1'b0;
    tick();
    checks++;
    if (an_n !== 6'h3F || seg_n !== 8'hFF) begin
      errors++;
      $display("FAIL en_dark: an_n=%h seg_n=%h, want 3f ff", an_n, seg_n);
    end
    u_wat = 6'd38;
    repeat (3) tick();
    en = 1'b1;
    tick();
    checks++;
    if (an_n !== 6'h3E || seg_n !== 8'h80) begin
      errors++;
      $display("FAIL en_restart: an_n=%h seg_n=%h, want 3e 80", an_n, seg_n);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL en_model: an_n=%h seg_n=%h, want %h %h", an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fl_disp = 1'b1;
    while (!(((fl_run / BC) % 2) == 1 && ((run / SC) % 6) == 3) && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL rstmid_wait: blink-off at digit 3 not reached");
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (an_n !== 6'h3F || seg_n !== 8'hFF) begin
      errors++;
      $display("FAIL rstmid: an_n=%h seg_n=%h, want 3f ff", an_n, seg_n);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (an_n !== 6'h3E || seg_n !== 8'hC0) begin
      errors++;
      $display("FAIL rstmid_restart: an_n=%h seg_n=%h, want 3e c0", an_n, seg_n);
    end
    fl_disp = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) u_tot = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) u_cur = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) u_wat = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) fl_disp = ~fl_disp;
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0; else rst_n = 1'b1;
      tick();
      checks++;
      if (an_n !== exp_an || seg_n !== exp_seg) begin
        errors++;
        $display("FAIL random_model: cyc=%0d an_n=%h seg_n=%h, want %h %h", i, an_n, seg_n, exp_an, exp_seg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_static();
    test_no_tear();
    test_blink();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
